// File: rtl/multiplicacion_pkg.sv
// multiplicacion_pkg: shared FSM state encoding and default sizes for the sequential matrix multiplier
package multiplicacion_pkg;
    localparam int N_DEF  = 2;
    localparam int DW_DEF = 4;
    localparam int OW_DEF = 32;
    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;
endpackage

// File: rtl/mac_signed.sv
// mac_signed: signed multiply-accumulate with synchronous clear, acc wraps mod 2^OW
//   clk, rst      clock, asynchronous active-high reset
//   clear         zero the accumulator (wins over enable)
//   enable        add a*b into the accumulator
//   a, b          signed DW-bit operands
//   acc           registered signed OW-bit accumulator
module mac_signed import multiplicacion_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [OW-1:0] acc
);
    logic signed [2*DW-1:0] prod;
    assign prod = a * b;
    // size cast keeps signedness, so the product is sign-extended into OW
    always_ff @(posedge clk or posedge rst)
        if (rst) acc <= '0;
        else if (clear) acc <= '0;
        else if (enable) acc <= acc + OW'(prod);
endmodule

// File: rtl/multiplicacion_matrices_seq.sv
// multiplicacion_matrices_seq: signed NxN matrix product C = A x B on one shared MAC
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b A,B element pairs, row-major
//   out_valid/out_ready         C element stream handshake
//   out_data/out_last           C element (row-major), last marks c[N-1][N-1]
//   busy                        high while computing or emitting
module multiplicacion_matrices_seq import multiplicacion_pkg::*; #(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);
    localparam int IW = $clog2(N);
    localparam int AW = $clog2(N*N);
    logic [1:0]           state;
    logic [AW-1:0]        li;
    logic [IW-1:0]        i, j, k;
    logic signed [DW-1:0] a_mem [N*N];
    logic signed [DW-1:0] b_mem [N*N];
    logic [AW-1:0]        a_idx, b_idx;
    logic                 beat, last_beat, hs, mac_last, clear;
    assign in_ready  = state == LOAD && !rst;
    assign out_valid = state == EMIT;
    assign busy      = state != LOAD;
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && li == AW'(N*N-1);
    assign hs        = out_valid && out_ready;
    assign mac_last  = k == IW'(N-1);
    // acc doubles as the out_data register: it holds still through EMIT
    // and restarts only once the element has been taken
    assign clear     = last_beat || (hs && !out_last);
    assign a_idx     = AW'(i*N + k);
    assign b_idx     = AW'(k*N + j);
    always_ff @(posedge clk)
        if (beat) begin
            a_mem[li] <= in_a;
            b_mem[li] <= in_b;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= LOAD;
            li       <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            out_last <= 1'b0;
        end else
            case (state)
                LOAD:
                    if (beat) begin
                        li    <= last_beat ? '0 : li + 1'b1;
                        state <= last_beat ? MAC : LOAD;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                    end
                MAC: begin
                    k     <= mac_last ? '0 : k + 1'b1;
                    state <= mac_last ? EMIT : MAC;
                    if (mac_last) out_last <= i == IW'(N-1) && j == IW'(N-1);
                end
                EMIT:
                    if (out_ready) begin
                        state    <= out_last ? LOAD : MAC;
                        out_last <= 1'b0;
                        j        <= (out_last || j == IW'(N-1)) ? '0 : j + 1'b1;
                        i        <= out_last ? '0 : (j == IW'(N-1) ? i + 1'b1 : i);
                    end
                default: state <= LOAD;
            endcase
    mac_signed #(.DW(DW), .OW(OW)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (state == MAC),
        .a      (a_mem[a_idx]),
        .b      (b_mem[b_idx]),
        .acc    (out_data)
    );
endmodule

// File: tb/tb_multiplicacion_matrices_seq.sv
// tb_multiplicacion_matrices_seq: randomized and directed checks of the matrix multiplier against a plain-arithmetic model
module tb_multiplicacion_matrices_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, sel3;
    logic [3:0]  in_a, in_b;
    logic        ir2, ov2, ol2, bz2, ir3, ov3, ol3, bz3;
    logic [31:0] od2, od3;
    logic        ir, ov, ol, bz;
    logic [31:0] od;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    multiplicacion_matrices_seq #(.N(2), .DW(4), .OW(32)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel3), .in_ready(ir2),
        .in_a(in_a), .in_b(in_b), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2), .out_last(ol2), .busy(bz2)
    );
    multiplicacion_matrices_seq #(.N(3), .DW(4), .OW(32)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel3), .in_ready(ir3),
        .in_a(in_a), .in_b(in_b), .out_valid(ov3), .out_ready(out_ready),
        .out_data(od3), .out_last(ol3), .busy(bz3)
    );

    assign ir = sel3 ? ir3 : ir2;
    assign ov = sel3 ? ov3 : ov2;
    assign ol = sel3 ? ol3 : ol2;
    assign bz = sel3 ? bz3 : bz2;
    assign od = sel3 ? od3 : od2;

    // mode 0: out_ready always 1, 1: random in_valid gaps and out_ready, 2: 5 stalled EMIT cycles
    task automatic run(input int n, input int a[9], input int b[9], input int mode, input string name);
        int   exp[$];
        int   got, beats, cyc, lb, fv, lh, hold, s;
        logic beat, pend, pl;
        logic [31:0] pd;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int m = 0; m < n; m++) s += a[r*n+m] * b[m*n+c];
                exp.push_back(s);
            end
        sel3 = (n == 3);
        #1;
        got = 0; beats = 0; cyc = 0; lb = -1; fv = -1; lh = -1; hold = 0; pend = 0; pl = 0; pd = '0;
        in_a = 4'(a[0]);
        in_b = 4'(b[0]);
        while (got < n*n && cyc < 500) begin
            in_valid = beats < n*n ? (mode == 1 ? 1'($urandom_range(1)) : 1'b1) : 1'b0;
            out_ready = mode == 1 ? 1'($urandom_range(1)) : 1'b1;
            if (mode == 2 && ov && hold < 5) begin
                out_ready = 1'b0;
                hold++;
            end
            if (pend) begin
                checks++;
                if (ov !== 1'b1 || od !== pd || ol !== pl) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", name, ov, $signed(od), ol, $signed(pd), pl);
                end
            end
            pend = 0;
            if (ov) begin
                if (fv < 0) begin
                    fv = cyc;
                    checks++;
                    if (fv - lb != n + 1) begin
                        errors++;
                        $display("FAIL %s first_latency: got %0d want %0d", name, fv - lb, n + 1);
                    end
                end
                checks++;
                if (ir !== 1'b0) begin
                    errors++;
                    $display("FAIL %s in_ready_in_emit: got %b want 0", name, ir);
                end
                if (out_ready) begin
                    checks++;
                    if ($signed(od) !== exp[got] || ol !== (got == n*n-1)) begin
                        errors++;
                        $display("FAIL %s elem%0d: got %0d last=%b want %0d last=%b", name, got, $signed(od), ol, exp[got], got == n*n-1);
                    end
                    if (mode == 0 && lh >= 0) begin
                        checks++;
                        if (cyc - lh != n + 1) begin
                            errors++;
                            $display("FAIL %s spacing: got %0d want %0d", name, cyc - lh, n + 1);
                        end
                    end
                    lh = cyc;
                    got++;
                end else begin
                    pend = 1;
                    pd = od;
                    pl = ol;
                end
            end
            beat = in_valid && ir;
            @(posedge clk);
            #1;
            if (beat) begin
                beats++;
                if (beats == n*n) begin
                    in_valid = 1'b0;
                    lb = cyc;
                end else begin
                    in_a = 4'(a[beats]);
                    in_b = 4'(b[beats]);
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != n*n) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, got, n*n);
        end
        checks++;
        if (ir !== 1'b1 || ov !== 1'b0 || bz !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_load: got ir=%b ov=%b busy=%b want 1 0 0", name, ir, ov, bz);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel3 = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ov2 !== 1'b0 || od2 !== 32'd0 || ol2 !== 1'b0 || ir2 !== 1'b0 || bz2 !== 1'b0 ||
            ov3 !== 1'b0 || od3 !== 32'd0 || ir3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%0d l=%b ir=%b busy=%b want 0 0 0 0 0", ov2, od2, ol2, ir2, bz2);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ir2 !== 1'b1 || ir3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b%b want 11", ir2, ir3);
        end
    endtask

    task automatic test_basic;
        int a[9], b[9];
        a = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        b = '{5, 6, 7, -8, 0, 0, 0, 0, 0};
        run(2, a, b, 0, "basic");
    endtask

    task automatic test_extreme;
        int a[9];
        a = '{-8, -8, -8, -8, 0, 0, 0, 0, 0};
        run(2, a, a, 0, "extreme");
    endtask

    task automatic test_backpressure;
        int a[9], b[9];
        a = '{2, -3, 7, 1, 0, 0, 0, 0, 0};
        b = '{-4, 5, 6, -7, 0, 0, 0, 0, 0};
        run(2, a, b, 2, "backpressure");
    endtask

    task automatic test_reset_midload;
        int a[9], b[9];
        sel3 = 1'b0;
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ov2 !== 1'b0 || od2 !== 32'd0 || ol2 !== 1'b0 || ir2 !== 1'b0 || bz2 !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset: got v=%b d=%0d l=%b ir=%b busy=%b want 0 0 0 0 0", ov2, od2, ol2, ir2, bz2);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        a = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        b = '{5, 6, 7, -8, 0, 0, 0, 0, 0};
        run(2, a, b, 0, "after_reset");
    endtask

    task automatic test_n3;
        int a[9], b[9];
        a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        b = '{1, 2, 3, 4, 5, 6, -7, -6, -5};
        run(3, a, b, 0, "n3_identity");
    endtask

    task automatic test_random;
        int a[9], b[9];
        for (int t = 0; t < 20; t++) begin
            for (int e = 0; e < 9; e++) begin
                a[e] = int'($urandom_range(4)) - 2;
                b[e] = int'($urandom_range(4)) - 2;
            end
            run(2, a, b, 1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extreme();
        test_backpressure();
        test_reset_midload();
        test_n3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
